// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the register file write port: buffers results,
// drains one per cycle, and forwards the youngest pending value to both readers.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_reg,
    input  logic [DATA_W-1:0]         in_data,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic                      regwrite_con,
    input  logic [ADDR_W-1:0]         read_reg1,
    input  logic [ADDR_W-1:0]         read_reg2,
    output logic                      fwd1_hit,
    output logic [DATA_W-1:0]         fwd1_data,
    output logic                      fwd2_hit,
    output logic [DATA_W-1:0]         fwd2_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
    logic [ADDR_W-1:0] mem_reg_d  [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  idx;

    // Readiness depends only on registered occupancy, so a full queue refuses
    // a request even on the edge where the head drains.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign pop      = (count_q != '0);
    // Writes to register zero complete the handshake but are never stored.
    assign push     = in_valid && in_ready && (in_reg != '0);

    assign count        = count_q;
    assign regwrite_con = regwrite_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;

    always_comb begin
        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        if (push) begin
            mem_reg_d[wr_ptr_q]  = in_reg;
            mem_data_d[wr_ptr_q] = in_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            regwrite_d = 1'b1;
            wreg_d     = mem_reg_q[rd_ptr_q];
            wdata_d    = mem_data_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Storage contents are qualified by the pointers and count, so no reset.
    always_ff @(posedge clk) begin
        mem_reg_q  <= mem_reg_d;
        mem_data_q <= mem_data_d;
    end

    // Scan oldest to youngest and let later matches overwrite earlier ones, so
    // the youngest pending write wins; the output stage is older than any entry.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = '0;

        if (regwrite_q && (read_reg1 != '0) && (wreg_q == read_reg1)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = wdata_q;
        end
        if (regwrite_q && (read_reg2 != '0) && (wreg_q == read_reg2)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = wdata_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((read_reg1 != '0) && (mem_reg_q[idx] == read_reg1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data_q[idx];
                end
                if ((read_reg2 != '0) && (mem_reg_q[idx] == read_reg2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed vector table, hand-written reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              regwrite_con;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic [2:0]        count;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .write_reg(write_reg), .write_data(write_data), .regwrite_con(regwrite_con),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model: pending writes in arrival order plus the output stage.
    ent_t              mq[$];
    logic              m_rw    = 1'b0;
    logic [ADDR_W-1:0] m_wreg  = '0;
    logic [DATA_W-1:0] m_wdata = '0;

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic              e_ready;
        logic              e_rw;
        logic [ADDR_W-1:0] e_wreg;
        logic [DATA_W-1:0] e_wdata;
        logic [2:0]        e_cnt;
        logic              e_h1;
        logic [DATA_W-1:0] e_d1;
        logic              e_h2;
        logic [DATA_W-1:0] e_d2;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [ADDR_W-1:0] r,
                         input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2);
        reset     = rst;
        in_valid  = v;
        in_reg    = r;
        in_data   = d;
        read_reg1 = a1;
        read_reg2 = a2;
    endtask

    function automatic void model_fwd(input logic [ADDR_W-1:0] a, output logic hit,
                                      output logic [DATA_W-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (a == '0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == a) begin
                hit  = 1'b1;
                data = mq[i].d;
                return;
            end
        end
        if (m_rw && m_wreg == a) begin
            hit  = 1'b1;
            data = m_wdata;
        end
    endfunction

    // Clock edge: update the model from the inputs the DUT samples, then move
    // to the falling edge where the next inputs are applied.
    task automatic advance();
        ent_t e;
        bit   acc;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_rw    = 1'b0;
            m_wreg  = '0;
            m_wdata = '0;
        end else begin
            acc = in_valid && (mq.size() != DEPTH);
            if (mq.size() > 0) begin
                e       = mq.pop_front();
                m_rw    = 1'b1;
                m_wreg  = e.r;
                m_wdata = e.d;
            end else begin
                m_rw = 1'b0;
            end
            if (acc && in_reg != '0) begin
                e.r = in_reg;
                e.d = in_data;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_vec(input int k, input vec_t t);
        drive(1'b0, t.v, t.r, t.d, t.a1, t.a2);
        #1;
        n_vec++;
        chk($sformatf("v%0d_in_ready", k),   32'(in_ready),     32'(t.e_ready));
        chk($sformatf("v%0d_regwrite", k),   32'(regwrite_con), 32'(t.e_rw));
        chk($sformatf("v%0d_write_reg", k),  32'(write_reg),    32'(t.e_wreg));
        chk($sformatf("v%0d_write_data", k), write_data,        t.e_wdata);
        chk($sformatf("v%0d_count", k),      32'(count),        32'(t.e_cnt));
        chk($sformatf("v%0d_fwd1_hit", k),   32'(fwd1_hit),     32'(t.e_h1));
        chk($sformatf("v%0d_fwd1_data", k),  fwd1_data,         t.e_d1);
        chk($sformatf("v%0d_fwd2_hit", k),   32'(fwd2_hit),     32'(t.e_h2));
        chk($sformatf("v%0d_fwd2_data", k),  fwd2_data,         t.e_d2);
        advance();
    endtask

    task automatic model_cycle(input string tag, input logic rst, input logic v,
                               input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                               input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        logic              h1, h2;
        logic [DATA_W-1:0] d1, d2;
        drive(rst, v, r, d, a1, a2);
        #1;
        n_vec++;
        model_fwd(a1, h1, d1);
        model_fwd(a2, h2, d2);
        chk({tag, "_in_ready"},   32'(in_ready),     32'(mq.size() != DEPTH));
        chk({tag, "_count"},      32'(count),        32'(mq.size()));
        chk({tag, "_regwrite"},   32'(regwrite_con), 32'(m_rw));
        chk({tag, "_write_reg"},  32'(write_reg),    32'(m_wreg));
        chk({tag, "_write_data"}, write_data,        m_wdata);
        chk({tag, "_fwd1_hit"},   32'(fwd1_hit),     32'(h1));
        chk({tag, "_fwd1_data"},  fwd1_data,         d1);
        chk({tag, "_fwd2_hit"},   32'(fwd2_hit),     32'(h2));
        chk({tag, "_fwd2_data"},  fwd2_data,         d2);
        advance();
    endtask

    initial begin
        //          v     r     d             a1    a2  | rdy   rw    wreg  wdata         cnt   h1    d1        h2    d2
        tbl[0]  = '{1'b1, 5'd8, 32'h0000000F, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd1, 1'b1, 32'hF,    1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 1'b1, 1'b1, 5'd8, 32'hF,        3'd0, 1'b1, 32'hF,    1'b0, 32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 32'hF,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd3, 32'h7,        5'd3, 5'd0, 1'b1, 1'b0, 5'd8, 32'hF,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[5]  = '{1'b1, 5'd3, 32'h9,        5'd3, 5'd0, 1'b1, 1'b0, 5'd8, 32'hF,        3'd1, 1'b1, 32'h7,    1'b0, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 32'h7,        3'd1, 1'b1, 32'h9,    1'b0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 32'h9,        3'd0, 1'b1, 32'h9,    1'b1, 32'h9};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 32'h9,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[9]  = '{1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 32'h9,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 32'h9,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd8, 1'b1, 1'b0, 5'd3, 32'h9,        3'd0, 1'b0, 32'h0,    1'b0, 32'h0};

        drive(1'b1, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        advance();
        advance();
        reset = 1'b0;

        for (int k = 0; k < 12; k++) apply_vec(k, tbl[k]);

        // Back-to-back pushes, then reset while the output stage is live.
        model_cycle("b2b0", 1'b0, 1'b1, 5'd10, 32'hA0A0_0001, 5'd10, 5'd11);
        model_cycle("b2b1", 1'b0, 1'b1, 5'd11, 32'hA0A0_0002, 5'd10, 5'd11);
        model_cycle("b2b2", 1'b0, 1'b1, 5'd12, 32'hA0A0_0003, 5'd11, 5'd12);
        #1;
        chk("pre_rst_regwrite", 32'(regwrite_con), 32'd1);
        model_cycle("rst_mid", 1'b1, 1'b0, '0, '0, 5'd12, 5'd11);
        #1;
        chk("post_rst_regwrite", 32'(regwrite_con), 32'd0);
        chk("post_rst_count",    32'(count),        32'd0);
        chk("post_rst_fwd",      32'(fwd1_hit),     32'd0);
        for (int k = 0; k < 4; k++) begin
            model_cycle($sformatf("idle%0d", k), 1'b0, 1'b0, '0, '0, 5'd12, 5'd11);
            chk($sformatf("idle%0d_no_write", k), 32'(regwrite_con), 32'd0);
        end

        for (int k = 0; k < 500; k++) begin
            model_cycle($sformatf("rnd%0d", k),
                        ($urandom_range(0, 59) == 0),
                        ($urandom_range(0, 3) != 0),
                        ADDR_W'($urandom_range(0, 7)),
                        $urandom(),
                        ADDR_W'($urandom_range(0, 7)),
                        ADDR_W'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
